rr_onehot_mux_reg: RTL and testbench
====================================

Name: rr_onehot_mux_reg

Overview:
- Parametrised N-channel, DATA_W-wide selector with per-channel valid/ready handshakes.
- Generalises the 4:1 one-hot bit mux in three ways: the select is generated internally by an arbiter (fixed-priority or round-robin), the output is registered, and the output stage supports backpressure.
- Sits between multiple producers and a single consumer.
- Transfers one word per accepted cycle, with one cycle of latency.

Parameters:
- NUM_CH, 4, number of input channels; must be >= 2.
- DATA_W, 8, width of each channel's data word.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- mode_i  input  1  arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.
- in_valid_i  input  NUM_CH  per-channel request/valid.
- in_data_i  input  NUM_CH*DATA_W  packed channel data; channel k occupies bits [k*DATA_W +: DATA_W].
- in_ready_o  output  NUM_CH  per-channel accept, one-hot or zero.
- out_valid_o  output  1  registered output word valid.
- out_data_o  output  DATA_W  registered output word.
- out_sel_o  output  NUM_CH  registered one-hot source of the current out_data_o.
- out_ready_i  input  1  consumer accept.

Behaviour:
- Reset (synchronous, reset=1 at a clk edge):
  - out_valid_o=0, out_data_o=0, out_sel_o=0, round-robin pointer ptr=0.
  - Reset wins over any simultaneous handshake.
  - Any word held in the output register is discarded.
- Output stage state:
  - can_load = ~out_valid_o | out_ready_i.
  - The stage accepts a new word in the same cycle the current one drains (full throughput).
- Grant (combinational):
  - Mode 0: gnt = lowest-index set bit of in_valid_i.
  - Mode 1: gnt = first set bit of in_valid_i searching from index ptr upward, wrapping NUM_CH-1 -> 0.
  - gnt is one-hot, or zero if in_valid_i==0.
- Handshake:
  - in_ready_o = gnt & {NUM_CH{can_load}}. Channel k transfers when in_valid_i[k] & in_ready_o[k].
  - in_ready_o may depend combinationally on out_ready_i and in_valid_i.
  - Producers must hold valid and data stable until accepted. The block does not rely on this for correctness; it samples data only on acceptance.
- Load (when can_load & |gnt):
  - out_data_o <= the granted channel's data word.
  - out_sel_o <= gnt.
  - out_valid_o <= 1.
- Drain without load (out_valid_o & out_ready_i & ~|gnt): out_valid_o <= 0; out_data_o and out_sel_o hold their last values.
- Stall (out_valid_o & ~out_ready_i): all outputs hold; in_ready_o=0.
- Pointer:
  - On every transfer in mode 1, ptr <= (granted index + 1) mod NUM_CH.
  - In mode 0 ptr holds.
  - ptr width is clog2(NUM_CH); wrap is explicit for non-power-of-2 NUM_CH.
- Mode change: mode_i is sampled combinationally each cycle, so a change takes effect on the next grant. ptr is not reset on a mode change.
- Latency: an input accepted at edge t appears on out_valid_o/out_data_o after edge t (visible in cycle t+1).
- Fairness: in mode 1, with all channels continuously valid and out_ready_i=1, grants cycle 0,1,...,NUM_CH-1,0,...
- Starvation: in mode 0 starvation of higher indices is permitted.
- No X propagation: out_data_o is never loaded from a non-granted channel.

Test Plan:
- Reset mid-stall:
  - Stimulus: load data 0xA5 from ch2, hold out_ready_i=0, assert reset for 1 cycle.
  - Required: next cycle out_valid_o=0, out_data_o=0, out_sel_o=0; the following grant in mode 1 starts search at ch0.
- Fixed priority:
  - Stimulus: mode_i=0, in_valid_i=4'b1010, data ch1=0x11, ch3=0x33, out_ready_i=1 for 3 cycles.
  - Required: in_ready_o=4'b0010 each cycle; out_data_o=0x11, out_sel_o=4'b0010 every cycle; ch3 never accepted.
- Round-robin rotation:
  - Stimulus: mode_i=1, in_valid_i=4'b1111, data ch k = 0x10+k, out_ready_i=1.
  - Required: out_data_o sequence 0x10,0x11,0x12,0x13,0x10; one word per cycle; ptr wraps 3->0.
- Round-robin skip and wrap:
  - Stimulus: mode_i=1, ptr=3, in_valid_i=4'b0101.
  - Required: grant ch0 (wrap), ptr->1; next grant ch2, ptr->3; next grant ch0.
- Backpressure:
  - Stimulus: output full with 0x22, out_ready_i=0 for 3 cycles, ch1 valid with 0x44.
  - Required: in_ready_o=0 and outputs hold 0x22 for those 3 cycles. When out_ready_i rises, in the same cycle in_ready_o[1]=1 and 0x44 loads; out_valid_o stays 1 with no bubble.
- Non-power-of-2 width:
  - Stimulus: NUM_CH=3, DATA_W=16, mode_i=1, all valid.
  - Required: grant order 0,1,2,0; ptr never reaches 3; out_sel_o always one-hot among 3 bits.

Source files
------------

// File: rtl/rr_onehot_mux_reg.sv
// ---------------------------------------------------------------------------
// rr_onehot_mux_reg
//
// Merges NUM_CH valid/ready producers onto one registered valid/ready
// consumer port. An internal arbiter picks one requesting channel per cycle.
// In fixed-priority mode the lowest index wins. In round-robin mode the
// search starts at a rotating pointer. The granted word is captured into an
// output register. That register refills in the same cycle it drains, so a
// continuously ready consumer sees one word per clock.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   reset        synchronous, active-high; clears the output register and
//                the round-robin pointer and discards any held word
//   mode_i       0 = fixed priority (lowest index), 1 = round-robin
//   in_valid_i   per-channel request
//   in_data_i    packed channel words, channel k at [k*DATA_W +: DATA_W]
//   in_ready_o   per-channel accept, one-hot or zero
//   out_valid_o  output register holds a word
//   out_data_o   registered word
//   out_sel_o    registered one-hot source channel of out_data_o
//   out_ready_i  consumer accepts the current word
// ---------------------------------------------------------------------------
module rr_onehot_mux_reg #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     mode_i,
   input  logic [NUM_CH-1:0]        in_valid_i,
   input  logic [NUM_CH*DATA_W-1:0] in_data_i,
   output logic [NUM_CH-1:0]        in_ready_o,
   output logic                     out_valid_o,
   output logic [DATA_W-1:0]        out_data_o,
   output logic [NUM_CH-1:0]        out_sel_o,
   input  logic                     out_ready_i
);

   localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_CH - 1);

   // Registered state
   logic [PTR_W-1:0]  ptr_reg, ptr_next;
   logic              out_valid_reg, out_valid_next;
   logic [DATA_W-1:0] out_data_reg, out_data_next;
   logic [NUM_CH-1:0] out_sel_reg, out_sel_next;

   // Arbitration
   logic [NUM_CH-1:0] low_mask;
   logic [NUM_CH-1:0] req_upper;
   logic [NUM_CH-1:0] gnt_fixed;
   logic [NUM_CH-1:0] gnt_upper;
   logic [NUM_CH-1:0] gnt_rr;
   logic [NUM_CH-1:0] gnt;
   logic [PTR_W-1:0]  gnt_idx;

   // Datapath
   logic [DATA_W-1:0] gated_data [NUM_CH];
   logic [DATA_W-1:0] mux_data;
   logic              can_load;
   logic              load;

   // -----------------------------------------------------------------------
   // Round-robin arbiter, built from two lowest-bit pickers. The first
   // picker sees only the requests at or above ptr. The second sees all
   // requests and covers the wrap-around. The shift stays inside NUM_CH
   // bits because ptr < NUM_CH.
   // -----------------------------------------------------------------------
   assign low_mask  = (NUM_CH'(1) << ptr_reg) - NUM_CH'(1);
   assign req_upper = in_valid_i & ~low_mask;

   // x & (~x + 1) isolates the lowest set bit, which keeps the grant one-hot.
   assign gnt_fixed = in_valid_i & (~in_valid_i + NUM_CH'(1));
   assign gnt_upper = req_upper  & (~req_upper  + NUM_CH'(1));
   assign gnt_rr    = (|req_upper) ? gnt_upper : gnt_fixed;
   assign gnt       = mode_i ? gnt_rr : gnt_fixed;

   // Binary index of the one-hot grant, used to advance the pointer.
   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (gnt[i]) begin
            gnt_idx = PTR_W'(i);
         end
      end
   end

   // -----------------------------------------------------------------------
   // AND-OR one-hot mux. A non-granted channel is forced to zero before the
   // OR, so its contents (even X) never reach the output register.
   // -----------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_gate
         assign gated_data[gi] = in_data_i[gi*DATA_W +: DATA_W] & {DATA_W{gnt[gi]}};
      end
   endgenerate

   always_comb begin
      mux_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         mux_data = mux_data | gated_data[i];
      end
   end

   // -----------------------------------------------------------------------
   // Handshake. The output register can take a word when it is empty or is
   // draining this cycle. This keeps full throughput under a ready consumer.
   // -----------------------------------------------------------------------
   assign can_load   = ~out_valid_reg | out_ready_i;
   assign in_ready_o = gnt & {NUM_CH{can_load}};
   assign load       = can_load & (|gnt);

   always_comb begin
      out_valid_next = out_valid_reg;
      out_data_next  = out_data_reg;
      out_sel_next   = out_sel_reg;
      ptr_next       = ptr_reg;

      if (load) begin
         out_valid_next = 1'b1;
         out_data_next  = mux_data;
         out_sel_next   = gnt;
      end else if (out_valid_reg && out_ready_i) begin
         // Drain with nothing to refill: data and source keep their values.
         out_valid_next = 1'b0;
      end

      // The pointer moves past the winner only on a round-robin transfer.
      // The wrap is explicit so a NUM_CH that is not a power of two stays
      // in range.
      if (load && mode_i) begin
         ptr_next = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_reg       <= '0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_sel_reg   <= '0;
      end else begin
         ptr_reg       <= ptr_next;
         out_valid_reg <= out_valid_next;
         out_data_reg  <= out_data_next;
         out_sel_reg   <= out_sel_next;
      end
   end

   assign out_valid_o = out_valid_reg;
   assign out_data_o  = out_data_reg;
   assign out_sel_o   = out_sel_reg;

endmodule

// File: tb/tb_rr_onehot_mux_reg.sv
// ---------------------------------------------------------------------------
// tb_rr_onehot_mux_reg
//
// Directed bench for rr_onehot_mux_reg. It drives a 4x8 instance and a
// 3x16 instance. The stimulus checks in_ready_o and pushes each expected
// output word into a queue. A monitor pops the queue and compares every
// time the DUT hands a word to the consumer.
// ---------------------------------------------------------------------------
module tb_rr_onehot_mux_reg;

   logic clk;
   logic reset;

   // 4-channel, 8-bit instance
   logic        mode4;
   logic [3:0]  valid4;
   logic [31:0] data4;
   logic [3:0]  ready4;
   logic        ov4;
   logic [7:0]  od4;
   logic [3:0]  os4;
   logic        ordy4;

   // 3-channel, 16-bit instance
   logic        mode3;
   logic [2:0]  valid3;
   logic [47:0] data3;
   logic [2:0]  ready3;
   logic        ov3;
   logic [15:0] od3;
   logic [2:0]  os3;
   logic        ordy3;

   int n_checks;
   int n_fail;

   logic [63:0] exp_q4 [$];
   logic [63:0] exp_q3 [$];

   rr_onehot_mux_reg #(.NUM_CH(4), .DATA_W(8)) dut4 (
      .clk(clk), .reset(reset), .mode_i(mode4), .in_valid_i(valid4),
      .in_data_i(data4), .in_ready_o(ready4), .out_valid_o(ov4),
      .out_data_o(od4), .out_sel_o(os4), .out_ready_i(ordy4)
   );

   rr_onehot_mux_reg #(.NUM_CH(3), .DATA_W(16)) dut3 (
      .clk(clk), .reset(reset), .mode_i(mode3), .in_valid_i(valid3),
      .in_data_i(data3), .in_ready_o(ready3), .out_valid_o(ov3),
      .out_data_o(od3), .out_sel_o(os3), .out_ready_i(ordy3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end else begin
         $display("ok   %s: %0h", nm, act);
      end
   endtask

   // Monitors: a word is consumed when valid and ready are both high.
   always @(negedge clk) begin
      logic [63:0] e;
      if (!reset && ov4 && ordy4) begin
         if (exp_q4.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL mon4_unexpected: got data %0h sel %b, expected nothing", od4, os4);
         end else begin
            e = exp_q4.pop_front();
            check("mon4_data", 64'(od4), 64'(e[7:0]));
            check("mon4_sel",  64'(os4), 64'(e[11:8]));
         end
      end
   end

   always @(negedge clk) begin
      logic [63:0] e;
      if (!reset && ov3 && ordy3) begin
         if (exp_q3.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL mon3_unexpected: got data %0h sel %b, expected nothing", od3, os3);
         end else begin
            e = exp_q3.pop_front();
            check("mon3_data", 64'(od3), 64'(e[15:0]));
            check("mon3_sel",  64'(os3), 64'(e[18:16]));
            check("mon3_sel_onehot", 64'($onehot(os3)), 64'(1));
         end
      end
   end

   // One cycle on the 4-channel DUT. The task is entered just after a
   // rising edge and returns just after the next one.
   task automatic step4(input logic m, input logic [3:0] v, input logic [31:0] d,
                        input logic r, input logic [3:0] exp_rdy, input logic push,
                        input logic [7:0] exp_d);
      mode4  = m;
      valid4 = v;
      data4  = d;
      ordy4  = r;
      #1;
      check("in_ready4", 64'(ready4), 64'(exp_rdy));
      if (push) exp_q4.push_back({52'd0, exp_rdy, exp_d});
      @(posedge clk);
      #1;
   endtask

   task automatic step3(input logic [2:0] v, input logic [47:0] d, input logic r,
                        input logic [2:0] exp_rdy, input logic push, input logic [15:0] exp_d);
      mode3  = 1'b1;
      valid3 = v;
      data3  = d;
      ordy3  = r;
      #1;
      check("in_ready3", 64'(ready3), 64'(exp_rdy));
      if (push) exp_q3.push_back({45'd0, exp_rdy, exp_d});
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset = 1'b1;
      mode4 = 1'b0; valid4 = '0; data4 = '0; ordy4 = 1'b0;
      mode3 = 1'b0; valid3 = '0; data3 = '0; ordy3 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 64'(ov4), 64'(0));
      check("rst_data",  64'(od4), 64'(0));
      check("rst_sel",   64'(os4), 64'(0));
      check("rst_valid3", 64'(ov3), 64'(0));
      reset = 1'b0;

      // Reset while a word is stalled in the output register.
      step4(1'b1, 4'b0100, 32'h00A5_0000, 1'b0, 4'b0100, 1'b0, 8'h00);
      check("stall_valid", 64'(ov4), 64'(1));
      check("stall_data",  64'(od4), 64'hA5);
      check("stall_sel",   64'(os4), 64'(4'b0100));
      step4(1'b1, 4'b0100, 32'h00A5_0000, 1'b0, 4'b0000, 1'b0, 8'h00);
      reset = 1'b1;
      step4(1'b1, 4'b0100, 32'h00A5_0000, 1'b0, 4'b0000, 1'b0, 8'h00);
      reset = 1'b0;
      check("midrst_valid", 64'(ov4), 64'(0));
      check("midrst_data",  64'(od4), 64'(0));
      check("midrst_sel",   64'(os4), 64'(0));

      // Round-robin rotation. The pointer restarts at ch0 after reset.
      step4(1'b1, 4'b1111, 32'h1312_1110, 1'b1, 4'b0001, 1'b1, 8'h10);
      step4(1'b1, 4'b1111, 32'h1312_1110, 1'b1, 4'b0010, 1'b1, 8'h11);
      step4(1'b1, 4'b1111, 32'h1312_1110, 1'b1, 4'b0100, 1'b1, 8'h12);
      step4(1'b1, 4'b1111, 32'h1312_1110, 1'b1, 4'b1000, 1'b1, 8'h13);
      step4(1'b1, 4'b1111, 32'h1312_1110, 1'b1, 4'b0001, 1'b1, 8'h10);

      // Fixed priority: ch1 always beats ch3.
      step4(1'b0, 4'b1010, 32'h3300_1100, 1'b1, 4'b0010, 1'b1, 8'h11);
      step4(1'b0, 4'b1010, 32'h3300_1100, 1'b1, 4'b0010, 1'b1, 8'h11);
      step4(1'b0, 4'b1010, 32'h3300_1100, 1'b1, 4'b0010, 1'b1, 8'h11);

      // Round-robin skip and wrap. Granting ch2 moves ptr to 3.
      step4(1'b1, 4'b0100, 32'h0052_0050, 1'b1, 4'b0100, 1'b1, 8'h52);
      step4(1'b1, 4'b0101, 32'h0052_0050, 1'b1, 4'b0001, 1'b1, 8'h50);
      step4(1'b1, 4'b0101, 32'h0052_0050, 1'b1, 4'b0100, 1'b1, 8'h52);
      step4(1'b1, 4'b0101, 32'h0052_0050, 1'b1, 4'b0001, 1'b1, 8'h50);

      // Backpressure: 0x22 is held, then refilled with 0x44 with no bubble.
      step4(1'b0, 4'b0010, 32'h0000_2200, 1'b1, 4'b0010, 1'b1, 8'h22);
      for (int i = 0; i < 3; i++) begin
         step4(1'b0, 4'b0010, 32'h0000_4400, 1'b0, 4'b0000, 1'b0, 8'h00);
         check("bp_hold_valid", 64'(ov4), 64'(1));
         check("bp_hold_data",  64'(od4), 64'h22);
      end
      step4(1'b0, 4'b0010, 32'h0000_4400, 1'b1, 4'b0010, 1'b1, 8'h44);
      check("bp_nobubble_valid", 64'(ov4), 64'(1));
      check("bp_nobubble_data",  64'(od4), 64'h44);
      step4(1'b0, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'h00);
      check("drain_valid", 64'(ov4), 64'(0));
      check("drain_data_hold", 64'(od4), 64'h44);
      check("drain_sel_hold",  64'(os4), 64'(4'b0010));

      // Non-power-of-2: 3 channels wrap from 2 back to 0.
      step3(3'b111, 48'h1002_1001_1000, 1'b1, 3'b001, 1'b1, 16'h1000);
      step3(3'b111, 48'h1002_1001_1000, 1'b1, 3'b010, 1'b1, 16'h1001);
      step3(3'b111, 48'h1002_1001_1000, 1'b1, 3'b100, 1'b1, 16'h1002);
      step3(3'b111, 48'h1002_1001_1000, 1'b1, 3'b001, 1'b1, 16'h1000);
      step3(3'b111, 48'h1002_1001_1000, 1'b1, 3'b010, 1'b1, 16'h1001);
      step3(3'b000, 48'h0, 1'b1, 3'b000, 1'b0, 16'h0000);

      repeat (3) @(posedge clk);
      #1;
      check("q4_empty", 64'(exp_q4.size()), 64'(0));
      check("q3_empty", 64'(exp_q3.size()), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
